// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the parallel-in / serial-out serializer.
package piso_serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Bit-counter width for a given word length.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w);
    endfunction

endpackage : piso_serializer_pkg

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out serializer with a valid/ready load handshake,
// shift-enable stalling and gapless back-to-back words.
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    input  logic             shift_ena,
    output logic             Dout,
    output logic             frame,
    output logic             done
);

    localparam int unsigned     CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] load_word;

    // Orient the incoming word so the first bit to send sits at the head (MSB).
    always_comb begin
        load_word = '0;
        if (MSB_FIRST) begin
            load_word = load_data;
        end else begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                load_word[i] = load_data[WIDTH-1-i];
            end
        end
    end

    // Next-state logic: load, shift, or finish a word (optionally reloading).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_valid) begin
                    sr_d    = load_word;
                    cnt_d   = CNT_LAST;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (shift_ena) begin
                    if (cnt_q != '0) begin
                        sr_d  = {sr_q[WIDTH-2:0], 1'b0};
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        done_d = 1'b1;
                        if (load_valid) begin
                            sr_d  = load_word;
                            cnt_d = CNT_LAST;
                        end else begin
                            sr_d    = '0;
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                sr_d    = '0;
            end
        endcase
    end

    // State, counter, shift register and done pulse registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            done_q  <= done_d;
        end
    end

    // The register is zero whenever idle, so the head bit alone gives Dout=0 outside a frame.
    assign Dout       = sr_q[WIDTH-1];
    assign frame      = (state_q == SHIFT);
    assign done       = done_q;
    assign load_ready = rst & ((state_q == IDLE) |
                               ((state_q == SHIFT) & (cnt_q == '0) & shift_ena));

endmodule : piso_serializer
